imem_responder: RTL and testbench

- Responder end of the instruction-fetch request/response interface: accepts word-address fetch requests from the fetch unit and returns instruction words after a fixed latency.
- Replaces the combinational instruction ROM with a multi-cycle, backpressured memory model that supports several outstanding requests.
- Holds a writable program array that is loaded after reset through a load port, then serves fetches in order. Supports flush on branch redirect.

---
 rtl/ooo_pkg.sv | 19 +
 rtl/imem_rsp_fifo.sv | 58 +++++
 rtl/imem_responder.sv | 160 ++++++++++++++++
 tb/tb_imem_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared types and constants for the in-order instruction memory responder.
package ooo_pkg;

    localparam int          XLEN            = 32;
    localparam logic [31:0] NOP_INSTR       = 32'h00000013;
    localparam int          IMEM_ENTRIES    = 16;
    localparam int          IMEM_ADDR_WIDTH = 4;

    typedef struct packed {
        logic [IMEM_ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]            instruction;
    } imem_rsp_t;

    typedef enum logic {
        IMEM_LOAD,
        IMEM_SERVE
    } imem_state_e;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous FIFO of instruction responses; pointers wrap naturally, full/empty come from the count.
module imem_rsp_fifo
    import ooo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  imem_rsp_t              push_data,
    input  logic                   pop,
    output imem_rsp_t              head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    imem_rsp_t        entries [DEPTH];
    logic             do_pop;
    logic             full;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = entries[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset: contents are only observed through a non-empty head.
    always_ff @(posedge clock) begin
        if (push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    // The outstanding-request limit upstream guarantees room for every push.
    assert property (@(posedge clock) disable iff (reset || clear) !(push && !do_pop && full));

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: loadable program array served with fixed latency, in order, with backpressure and flush.
module imem_responder
    import ooo_pkg::*;
#(
    parameter int MEM_ENTRIES     = 16,
    parameter int MEM_ADDR_WIDTH  = 4,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_valid,
    input  logic [MEM_ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]               load_data,
    input  logic                      load_done,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [MEM_ADDR_WIDTH-1:0] rsp_addr,
    output logic [31:0]               rsp_instruction,
    input  logic                      flush,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    imem_state_e      state_q;
    imem_state_e      state_d;
    logic             load_we;
    logic [XLEN-1:0]  mem_q [MEM_ENTRIES];
    logic [CNT_W-1:0] outstanding;
    logic             accept;
    logic             pop;
    logic             vld_p0;
    imem_rsp_t        data_p0;
    logic             push_vld;
    imem_rsp_t        push_data;
    imem_rsp_t        fifo_head;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IMEM_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_we   = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            IMEM_LOAD: begin
                load_we = load_valid;
                if (load_done) begin
                    state_d = IMEM_SERVE;
                end
            end
            IMEM_SERVE: begin
                req_ready = (outstanding < CNT_W'(MAX_OUTSTANDING)) && !flush;
            end
            default: state_d = IMEM_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_ENTRIES; i++) begin
                mem_q[i] <= NOP_INSTR;
            end
        end else if (load_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign accept = req_valid && req_ready;
    assign pop    = rsp_valid && rsp_ready;

    // Stage p0: array read in the accept cycle
    assign vld_p0 = accept;
    always_comb begin
        data_p0             = '0;
        data_p0.addr        = IMEM_ADDR_WIDTH'(req_addr);
        data_p0.instruction = mem_q[req_addr];
    end

    // Stages 1..LATENCY-1: registered delay line, the last stage feeds the FIFO
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_vld  = vld_p0;
            assign push_data = data_p0;
        end else begin : g_pipe
            logic      vld_pipe  [1:LATENCY-1];
            imem_rsp_t data_pipe [1:LATENCY-1];

            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_pipe[i] <= 1'b0;
                    end
                end else begin
                    vld_pipe[1] <= vld_p0;
                    for (int i = 2; i < LATENCY; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                    end
                end
            end

            always_ff @(posedge clock) begin
                data_pipe[1] <= data_p0;
                for (int i = 2; i < LATENCY; i++) begin
                    data_pipe[i] <= data_pipe[i-1];
                end
            end

            assign push_vld  = vld_pipe[LATENCY-1];
            assign push_data = data_pipe[LATENCY-1];
        end
    endgenerate

    // A flush clears the FIFO at the same edge, so a same-cycle push is dropped.
    imem_rsp_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .push     (push_vld),
        .push_data(push_data),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign rsp_valid       = !fifo_empty;
    assign rsp_addr        = fifo_empty ? '0 : MEM_ADDR_WIDTH'(fifo_head.addr);
    assign rsp_instruction = fifo_empty ? '0 : fifo_head.instruction;
    assign busy            = (outstanding != '0);

    // Every queued response is also an outstanding request.
    assert property (@(posedge clock) disable iff (reset) fifo_count <= outstanding);

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scenario bench for imem_responder against an in-order, fixed-latency queue model.
module tb_imem_responder;
    import ooo_pkg::*;

    localparam int L    = 2;
    localparam int MAXO = 4;
    localparam int AW   = 4;

    logic          clock;
    logic          reset;
    logic          load_valid;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_done;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [31:0]   rsp_instruction;
    logic          flush;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    imem_responder #(
        .MEM_ENTRIES(16), .MEM_ADDR_WIDTH(AW), .LATENCY(L), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
        .load_data(load_data), .load_done(load_done), .req_valid(req_valid),
        .req_ready(req_ready), .req_addr(req_addr), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_instruction(rsp_instruction),
        .flush(flush), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: program array, serve flag, and a queue of accepted words each due L cycles after accept.
    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   instr;
        int            due;
    } exp_t;

    exp_t        pend[$];
    logic [31:0] mem_m [16];
    bit          serve_m;
    int          cyc = 0;

    function automatic bit m_req_ready();
        return serve_m && (pend.size() < MAXO) && !flush;
    endfunction

    function automatic bit m_rsp_valid();
        return (pend.size() > 0) && (pend[0].due <= cyc);
    endfunction

    task automatic tick();
        bit   acc;
        bit   hs;
        exp_t e;
        acc = req_valid && m_req_ready();
        hs  = m_rsp_valid() && rsp_ready;
        if (reset) begin
            foreach (mem_m[i]) mem_m[i] = NOP_INSTR;
            serve_m = 1'b0;
            pend.delete();
        end else begin
            if (acc) begin
                e.addr  = req_addr;
                e.instr = mem_m[req_addr];
                e.due   = cyc + L;
            end
            if (!serve_m) begin
                if (load_valid) mem_m[load_addr] = load_data;
                if (load_done) serve_m = 1'b1;
            end
            if (flush) begin
                pend.delete();
            end else begin
                if (hs) void'(pend.pop_front());
                if (acc) pend.push_back(e);
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++; if ({req_ready, rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got rdy/vld/busy=%b required 000", {req_ready, rsp_valid, busy}); end
        n_cmp++; if (rsp_addr !== '0) begin n_fail++; $display("FAIL reset_rsp_addr: got %h required 0", rsp_addr); end
        n_cmp++; if (rsp_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_instr: got %h required 0", rsp_instruction); end
        reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_ready: got %b required 0", req_ready); end
    endtask

    task automatic test_load_gate();
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr   = AW'($urandom_range(0, 15));
            load_valid = (k != 2);
            load_done  = (k == 3);
            case (k)
                0: begin load_addr = 4'd0; load_data = 32'h00500093; end
                1: begin load_addr = 4'(8 + $urandom_range(0, 7)); load_data = $urandom; end
                default: begin load_addr = 4'd1; load_data = 32'h00308113; end
            endcase
            #1;
            n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL load_req_ready k=%0d: got %b required 0", k, req_ready); end
            n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL load_rsp_valid k=%0d: got %b required 0", k, rsp_valid); end
            tick();
        end
        req_valid = 1'b0;
        load_done = 1'b0;
        // Writes after entering SERVE must be ignored
        load_valid = 1'b1;
        load_addr  = 4'd0;
        load_data  = 32'hDEADBEEF;
        tick();
        load_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL load_no_rsp: got vld=%b busy=%b required 0 0", rsp_valid, busy); end
    endtask

    task automatic test_first_fetch();
        logic [AW-1:0] addrs [3];
        logic [31:0]   words [3];
        addrs = '{4'd0, 4'd5, 4'd1};
        words = '{32'h00500093, NOP_INSTR, 32'h00308113};
        rsp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            req_valid = 1'b1;
            req_addr  = addrs[j];
            #1;
            n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready a=%0d: got %b required 1", addrs[j], req_ready); end
            tick();
            req_valid = 1'b0;
            n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_early a=%0d: got vld %b required 0 at T+1", addrs[j], rsp_valid); end
            tick();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid a=%0d: got vld %b required 1 at T+2", addrs[j], rsp_valid); end
            n_cmp++; if (rsp_instruction !== words[j] || rsp_addr !== addrs[j]) begin n_fail++; $display("FAIL fetch_data: got %h@%0d required %h@%0d", rsp_instruction, rsp_addr, words[j], addrs[j]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int acc_cnt = 0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 8);
            req_addr  = AW'(k);
            #1;
            if (req_valid && req_ready) acc_cnt++;
            n_cmp++; if (rsp_valid !== (k >= 2 && k < 10)) begin n_fail++; $display("FAIL stream_valid k=%0d: got %b required %b", k, rsp_valid, (k >= 2 && k < 10)); end
            if (k >= 2 && k < 10) begin
                n_cmp++; if (rsp_addr !== AW'(k - 2) || rsp_instruction !== mem_m[k-2]) begin n_fail++; $display("FAIL stream_data k=%0d: got %h@%0d required %h@%0d", k, rsp_instruction, rsp_addr, mem_m[k-2], k - 2); end
            end
            n_cmp++; if (busy !== (k >= 1 && k <= 9)) begin n_fail++; $display("FAIL stream_busy k=%0d: got %b required %b", k, busy, (k >= 1 && k <= 9)); end
            tick();
        end
        n_cmp++; if (acc_cnt != 8) begin n_fail++; $display("FAIL stream_accepts: got %0d required 8", acc_cnt); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] sent [$];
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_addr = AW'($urandom_range(0, 15));
            #1;
            n_cmp++; if (req_ready !== (k < MAXO)) begin n_fail++; $display("FAIL bp_ready k=%0d: got %b required %b", k, req_ready, (k < MAXO)); end
            if (req_ready) sent.push_back(req_addr);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++; if (req_ready !== (k >= 1)) begin n_fail++; $display("FAIL bp_reready k=%0d: got %b required %b", k, req_ready, (k >= 1)); end
            n_cmp++; if (rsp_valid !== (k < MAXO)) begin n_fail++; $display("FAIL bp_valid k=%0d: got %b required %b", k, rsp_valid, (k < MAXO)); end
            if (k < MAXO && k < sent.size()) begin
                n_cmp++; if (rsp_addr !== sent[k] || rsp_instruction !== mem_m[sent[k]]) begin n_fail++; $display("FAIL bp_order k=%0d: got %h@%0d required %h@%0d", k, rsp_instruction, rsp_addr, mem_m[sent[k]], sent[k]); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = AW'($urandom_range(2, 15));
            tick();
        end
        flush = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b required 0", req_ready); end
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got vld=%b busy=%b required 0 0", rsp_valid, busy); end
        req_valid = 1'b1;
        req_addr  = 4'd1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_new_ready: got %b required 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale: got vld %b (%h) required 0", rsp_valid, rsp_instruction); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_instruction !== 32'h00308113 || rsp_addr !== 4'd1) begin n_fail++; $display("FAIL flush_new_rsp: got %b %h@%0d required 1 00308113@1", rsp_valid, rsp_instruction, rsp_addr); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got vld %b required 0", rsp_valid); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = AW'($urandom_range(0, 15));
            rsp_ready = (k >= 300) ? 1'b1 : ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            #1;
            n_cmp++; if (req_ready !== m_req_ready()) begin n_fail++; $display("FAIL rand_ready k=%0d: got %b required %b", k, req_ready, m_req_ready()); end
            n_cmp++; if (rsp_valid !== m_rsp_valid()) begin n_fail++; $display("FAIL rand_valid k=%0d: got %b required %b", k, rsp_valid, m_rsp_valid()); end
            n_cmp++; if (busy !== (pend.size() != 0)) begin n_fail++; $display("FAIL rand_busy k=%0d: got %b required %b", k, busy, (pend.size() != 0)); end
            if (m_rsp_valid()) begin
                n_cmp++; if (rsp_addr !== pend[0].addr || rsp_instruction !== pend[0].instr) begin n_fail++; $display("FAIL rand_data k=%0d: got %h@%0d required %h@%0d", k, rsp_instruction, rsp_addr, pend[0].instr, pend[0].addr); end
            end
            tick();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = AW'(k);
            tick();
        end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b required 1", busy); end
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        #1;
        n_cmp++; if ({req_ready, rsp_valid, busy} !== 3'b000 || rsp_addr !== '0 || rsp_instruction !== 32'h0) begin n_fail++; $display("FAIL rmid_outputs: got rdy/vld/busy=%b %h@%0d required 000 0@0", {req_ready, rsp_valid, busy}, rsp_instruction, rsp_addr); end
        reset     = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_load_state: got vld=%b rdy=%b required 0 0", rsp_valid, req_ready); end
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        for (int j = 0; j < 2; j++) begin
            req_valid = 1'b1;
            req_addr  = AW'(j);
            tick();
            req_valid = 1'b0;
            tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_instruction !== NOP_INSTR || rsp_addr !== AW'(j)) begin n_fail++; $display("FAIL rmid_nop a=%0d: got %b %h@%0d required 1 %h@%0d", j, rsp_valid, rsp_instruction, rsp_addr, NOP_INSTR, j); end
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_done  = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b0;
        flush      = 1'b0;
        foreach (mem_m[i]) mem_m[i] = NOP_INSTR;
        serve_m = 1'b0;
        @(negedge clock);
        test_reset();
        test_load_gate();
        test_first_fetch();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
